// File: rtl/li_expander_if.sv
// li_expander_if: load-immediate request in, encoded instruction words out.
interface li_expander_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [4:0]  in_rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [3:0]  out_eop;
    logic        out_last;
    logic [15:0] word_cnt;
    modport master (
        output in_valid, in_value, in_rt, out_ready,
        input  in_ready, out_valid, out_instr, out_eop, out_last, word_cnt
    );
    modport slave (
        input  in_valid, in_value, in_rt, out_ready,
        output in_ready, out_valid, out_instr, out_eop, out_last, word_cnt
    );
endinterface

// File: rtl/li_expander.sv
// li_expander: expands a 32-bit load-immediate into one or two MIPS words
// (addiu / ori / lui, or lui+ori for a full 32-bit constant).
module li_expander (
    input  logic          clk,
    input  logic          reset,
    li_expander_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;
    state_t state, next;
    logic [15:0] lo_q;
    logic [4:0]  rt_q;
    logic [31:0] instr_q;
    logic [3:0]  eop_q;
    logic        last_q;
    logic [15:0] cnt_q;
    logic        accept, fire, is_s, is_z, is_l;
    assign accept        = bus.in_valid && state == IDLE;
    assign fire          = bus.out_ready && state != IDLE;
    assign is_s          = (&bus.in_value[31:15]) || !(|bus.in_value[31:15]);
    assign is_z          = !(|bus.in_value[31:16]);
    assign is_l          = !(|bus.in_value[15:0]);
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state != IDLE;
    assign bus.out_instr = instr_q;
    assign bus.out_eop   = eop_q;
    assign bus.out_last  = last_q;
    assign bus.word_cnt  = cnt_q;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept ? EMIT1 : IDLE;
            EMIT1:   next = fire ? (last_q ? IDLE : EMIT2) : EMIT1;
            EMIT2:   next = fire ? IDLE : EMIT2;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= next;
    // Classification priority: sign-extendable, then zero-extendable, then low-half-zero, else pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            eop_q   <= '0;
            last_q  <= 1'b0;
            lo_q    <= '0;
            rt_q    <= '0;
        end else if (accept) begin
            lo_q    <= bus.in_value[15:0];
            rt_q    <= bus.in_rt;
            instr_q <= is_s ? {6'b001001, 5'd0, bus.in_rt, bus.in_value[15:0]} :
                       is_z ? {6'b001101, 5'd0, bus.in_rt, bus.in_value[15:0]} :
                              {6'b001111, 5'd0, bus.in_rt, bus.in_value[31:16]};
            eop_q   <= is_s ? 4'b0000 : is_z ? 4'b0001 : 4'b0010;
            last_q  <= is_s || is_z || is_l;
        end else if (fire && state == EMIT1 && !last_q) begin
            instr_q <= {6'b001101, rt_q, rt_q, lo_q};
            eop_q   <= 4'b0001;
            last_q  <= 1'b1;
        end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset)     cnt_q <= '0;
        else if (fire) cnt_q <= cnt_q + 16'd1;
endmodule

// File: tb/tb_li_expander.sv
// tb_li_expander: directed requests with a scoreboard queue checked by an independent output monitor.
module tb_li_expander;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_cnt = '0;
    logic [36:0] sb[$];
    li_expander_if bus ();
    li_expander dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && bus.in_ready !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        if (bus.in_ready !== 1'b1) chk("idle_timeout", {36'd0, bus.in_ready}, 37'd1);
    endtask

    task automatic send(input logic [31:0] v, input logic [4:0] rt, input int nw,
                        input logic [36:0] w0, input logic [36:0] w1);
        wait_idle();
        sb.push_back(w0);
        if (nw == 2) sb.push_back(w1);
        bus.in_valid = 1'b1;
        bus.in_value = v;
        bus.in_rt    = rt;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("latency", {36'd0, bus.out_valid}, 37'd1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                chk("in_ready_busy", {36'd0, bus.in_ready}, 37'd0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h expected none", bus.out_instr);
                end else begin
                    chk("word", {bus.out_instr, bus.out_eop, bus.out_last}, sb.pop_front());
                end
                exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_value  = '0;
        bus.in_rt     = '0;
        bus.out_ready = 1'b1;
        #1;
        chk("reset_valid", {36'd0, bus.out_valid}, 37'd0);
        chk("reset_ready", {36'd0, bus.in_ready}, 37'd1);
        chk("reset_regs", {bus.out_instr, bus.out_eop, bus.out_last}, 37'd0);
        chk("reset_cnt", {21'd0, bus.word_cnt}, 37'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(32'hFFFF8000, 5'd8, 1, {32'h24088000, 4'b0000, 1'b1}, '0);
        wait_idle();
        chk("cnt_s", {21'd0, bus.word_cnt}, 37'd1);
        send(32'h00008000, 5'd9, 1, {32'h34098000, 4'b0001, 1'b1}, '0);
        send(32'h12340000, 5'd10, 1, {32'h3C0A1234, 4'b0010, 1'b1}, '0);
        send(32'h00000005, 5'd0, 1, {32'h24000005, 4'b0000, 1'b1}, '0);
        wait_idle();
        chk("cnt_szl", {21'd0, bus.word_cnt}, {21'd0, exp_cnt});
        send(32'h12345678, 5'd11, 2, {32'h3C0B1234, 4'b0010, 1'b0}, {32'h356B5678, 4'b0001, 1'b1});
        wait_idle();
        chk("cnt_pair", {21'd0, bus.word_cnt}, 37'd6);
        bus.out_ready = 1'b0;
        send(32'hABCD1234, 5'd12, 2, {32'h3C0CABCD, 4'b0010, 1'b0}, {32'h358C1234, 4'b0001, 1'b1});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold", {bus.out_valid, bus.out_instr, bus.out_eop}, {1'b1, 32'h3C0CABCD, 4'b0010});
            chk("hold_last", {35'd0, bus.out_last, bus.in_ready}, 37'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("emit2_word", {bus.out_instr, bus.out_eop, bus.out_last}, {32'h358C1234, 4'b0001, 1'b1});
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", {36'd0, bus.out_valid}, 37'd0);
        chk("rst_mid_ready", {36'd0, bus.in_ready}, 37'd1);
        chk("rst_mid_cnt", {21'd0, bus.word_cnt}, 37'd0);
        sb.delete();
        exp_cnt = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("no_second_word", {36'd0, bus.out_valid}, 37'd0);
        end
        for (int i = 0; i < 32767; i++)
            send(32'h12345678, 5'd11, 2, {32'h3C0B1234, 4'b0010, 1'b0}, {32'h356B5678, 4'b0001, 1'b1});
        send(32'h00000005, 5'd0, 1, {32'h24000005, 4'b0000, 1'b1}, '0);
        wait_idle();
        chk("cnt_ffff", {21'd0, bus.word_cnt}, {21'd0, 16'hFFFF});
        send(32'h00000005, 5'd0, 1, {32'h24000005, 4'b0000, 1'b1}, '0);
        wait_idle();
        chk("cnt_wrap", {21'd0, bus.word_cnt}, 37'd0);
        chk("cnt_model", {21'd0, bus.word_cnt}, {21'd0, exp_cnt});
        chk("sb_drained", 37'(sb.size()), 37'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/li_expander.md
LI_EXPANDER -- requirements
Module: li_expander

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: a load-immediate request is present.
REQ-004 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-005 SHALL have port in_value, input, 32 bits: the constant to load.
REQ-006 SHALL have port in_rt, input, 5 bits: the destination register number.
REQ-007 SHALL have port out_valid, output, 1 bit: out_instr holds a valid instruction word.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts out_instr.
REQ-009 SHALL have port out_instr, output, 32 bits: the encoded MIPS instruction.
REQ-010 SHALL have port out_eop, output, 4 bits: extender op the word's immediate needs (0000 sign, 0001 zero, 0010 lui).
REQ-011 SHALL have port out_last, output, 1 bit: this is the final word of the current request.
REQ-012 SHALL have port word_cnt, output, 16 bits: running count of words accepted by the consumer.

Function
REQ-013 SHALL implement states IDLE, EMIT1 and EMIT2; in_ready SHALL be 1 exactly when the state is IDLE.
REQ-014 SHALL capture in_value and in_rt when in_valid&in_ready on the rising edge, enter EMIT1, and assert out_valid on the next cycle (latency 1).
REQ-015 SHALL classify on capture, in priority order: S = in_value[31:15] all equal; Z = in_value[31:16]==0; L = in_value[15:0]==0; otherwise P (pair).
REQ-016 SHALL, for case S, emit addiu {001001,00000,rt,value[15:0]} with out_eop=0000 and out_last=1.
REQ-017 SHALL, for case Z, emit ori {001101,00000,rt,value[15:0]} with out_eop=0001 and out_last=1.
REQ-018 SHALL, for case L, emit lui {001111,00000,rt,value[31:16]} with out_eop=0010 and out_last=1.
REQ-019 SHALL, for case P, emit in EMIT1 lui {001111,00000,rt,value[31:16]} with out_eop=0010 and out_last=0.
REQ-020 SHALL, for case P, then emit in EMIT2 ori {001101,rt,rt,value[15:0]} with out_eop=0001 and out_last=1.
REQ-021 SHALL keep out_instr, out_eop and out_last registered and stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on out_valid&out_ready: go from EMIT1 to EMIT2 if the word is not last, otherwise return to IDLE with out_valid=0 on the next cycle.
REQ-023 SHALL increment word_cnt by 1 on each out_valid&out_ready and wrap from 0xFFFF to 0x0000.
REQ-024 SHALL ignore in_valid outside IDLE; a request is never accepted in the same cycle an output handshake completes.
REQ-025 SHALL encode in_rt=0 normally, with no special-casing.
REQ-026 SHALL use out_ready only in EMIT1 and EMIT2; out_ready asserted while out_valid=0 has no effect.

Reset
REQ-027 SHALL, while reset=1 (asynchronously), force state to IDLE and set out_valid=0, out_instr=0, out_eop=0, out_last=0, word_cnt=0; in_ready=1 follows from IDLE.
REQ-028 SHALL drop any pending second word (EMIT2) on reset mid-request; it is not emitted after reset releases.

Verification
REQ-029 SHALL cover: value 0xFFFF8000, rt=8, out_ready=1 -> one word 0x24088000, eop=0000, last=1, word_cnt=1.
REQ-030 SHALL cover: value 0x00008000, rt=9 -> one word 0x34098000, eop=0001, last=1.
REQ-031 SHALL cover: value 0x12340000, rt=10 -> one word 0x3C0A1234, eop=0010, last=1.
REQ-032 SHALL cover: value 0x12345678, rt=11 -> 0x3C0B1234 (last=0), then 0x356B5678 (last=1), word_cnt +2, in_ready low throughout.
REQ-033 SHALL cover: case P with out_ready=0 for 3 cycles -> first word held stable, no state advance; then reset asserted in EMIT2 -> out_valid=0 and in_ready=1 immediately, no second word.
REQ-034 SHALL cover: preload word_cnt=0xFFFF via 65535 handshakes, then one more -> word_cnt=0x0000.
